// File: rtl/lfsr_10_pkg.sv
// Shared definitions for the 43-bit, 12-bit-per-beat lfsr_10 scrambler and descrambler.
package lfsr_10_pkg;

  localparam int LFSR_W = 43;
  localparam int BEAT_W = 12;

  // Galois feedback taps: bit 42 is folded into bits 0, TAP_A, TAP_B and TAP_C.
  localparam int TAP_A  = 5;
  localparam int TAP_B  = 22;
  localparam int TAP_C  = 27;

  typedef logic [LFSR_W-1:0] lfsr_t;
  typedef logic [BEAT_W-1:0] beat_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fsm_t;

  // One LFSR step: the next state, plus the line bit with the keystream removed.
  typedef struct packed {
    lfsr_t s;
    logic  d;
  } step_t;

  // 'b' is the line (scrambled) bit. The line bit is what enters bit 0 on both
  // ends, so the scrambler computes b = p ^ s[42] and calls this with b, while
  // the descrambler calls it with the received bit and uses .d as plain data.
  function automatic step_t lfsr_step(input lfsr_t s, input logic b);
    step_t r;
    logic  m;
    m          = s[LFSR_W-1];
    r.d        = b ^ m;
    r.s        = {s[LFSR_W-2:0], b};
    r.s[TAP_A] = m ^ s[TAP_A-1];
    r.s[TAP_B] = m ^ s[TAP_B-1];
    r.s[TAP_C] = m ^ s[TAP_C-1];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_10_desc_step.sv
// Combinational 12-bit unroll of the descrambler LFSR: bit 0 is processed first.
module lfsr_10_desc_step
  import lfsr_10_pkg::*;
(
  input  lfsr_t s_cur,
  input  beat_t bits,
  output lfsr_t s_nxt,
  output beat_t d
);

  lfsr_t [BEAT_W:0]   chain;
  step_t [BEAT_W-1:0] st;

  assign chain[0] = s_cur;

  // One lfsr_step per serial bit, chained through the state.
  for (genvar g = 0; g < BEAT_W; g++) begin : g_bit
    assign st[g]       = lfsr_step(chain[g], bits[g]);
    assign chain[g+1]  = st[g].s;
    assign d[g]        = st[g].d;
  end

  assign s_nxt = chain[BEAT_W];

endmodule

// File: rtl/lfsr_10_descrambler.sv
// Frame-based 12-bit-per-beat descrambler with valid/ready on both sides.
module lfsr_10_descrambler
  import lfsr_10_pkg::*;
#(
  parameter int WORDS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] seed_load,
  input  logic              start,
  input  logic              in_valid,
  input  logic [BEAT_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_data,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] state_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(WORDS + 1);

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  lfsr_t            lfsr_q, lfsr_nxt;
  beat_t            dout_q, d_nxt;
  logic             vld_q, done_q;
  logic             fire, take, last;

  lfsr_10_desc_step u_step (
    .s_cur (lfsr_q),
    .bits  (in_data),
    .s_nxt (lfsr_nxt),
    .d     (d_nxt)
  );

  // The single output register acts as a skid slot: accept when empty or draining.
  assign in_ready = (state_q == ST_RUN) && (!vld_q || out_ready);
  assign fire     = in_valid && in_ready;
  // start overrides a coincident handshake; that beat is dropped.
  assign take     = fire && !start;
  assign last     = (cnt_q == CNT_W'(WORDS - 1));

  // Next-state logic: start always (re)enters RUN, last accepted beat ends the frame.
  always_comb begin
    state_d = state_q;
    if (start)
      state_d = ST_RUN;
    else if (take && last)
      state_d = ST_IDLE;
  end

  // FSM, beat counter and LFSR state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q  <= '0;
        lfsr_q <= seed_load;
      end else if (take) begin
        cnt_q  <= cnt_q + CNT_W'(1);
        lfsr_q <= lfsr_nxt;
      end
    end
  end

  // Output register and done pulse; a pending beat survives start until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      dout_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= take && last;
      if (take) begin
        vld_q  <= 1'b1;
        dout_q <= d_nxt;
      end else if (out_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_data  = dout_q;
  assign state_out = lfsr_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_lfsr_10_descrambler.sv
// Directed bench for lfsr_10_descrambler: vector table plus frame-level sequences.
module tb_lfsr_10_descrambler;

  logic        clk = 1'b0;
  logic        rst;
  logic [42:0] seed_load;
  logic        start, in_valid, out_ready;
  logic [11:0] in_data;
  logic        in_ready, out_valid, busy, done;
  logic [11:0] out_data;
  logic [42:0] state_out;

  int n_cmp = 0;
  int n_err = 0;

  lfsr_10_descrambler #(.WORDS(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .seed_load (seed_load),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .state_out (state_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [42:0] seed;
    logic        iv;
    logic [11:0] id;
    logic        ordy;
    logic        ov;
    logic [11:0] od;
    logic [42:0] sto;
    logic        bsy;
  } vec_t;

  vec_t        tbl[8];
  logic [11:0] plain[64];
  logic [11:0] scr_w[64];
  logic [11:0] outq[$];
  int          done_cnt;
  int          done_at;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transmit-side reference: line bit = plain ^ s[42], and the line bit enters bit 0.
  function automatic logic [42:0] scr_beat(input logic [42:0] s, input logic [11:0] p,
                                           output logic [11:0] w);
    logic m;
    w = '0;
    for (int i = 0; i < 12; i++) begin
      m     = s[42];
      w[i]  = p[i] ^ m;
      s     = {s[41:0], w[i]};
      s[5]  = s[5]  ^ m;
      s[22] = s[22] ^ m;
      s[27] = s[27] ^ m;
    end
    return s;
  endfunction

  function automatic logic [42:0] make_frame(input logic [42:0] seed);
    logic [42:0] s;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      plain[i] = 12'($urandom);
      s = scr_beat(s, plain[i], scr_w[i]);
    end
    return s;
  endfunction

  // Output-side monitor, sampled on the falling edge away from input updates.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) outq.push_back(out_data);
    if (!rst && done) begin
      done_cnt++;
      done_at = outq.size();
    end
  end

  // Enters and leaves at posedge+1. Feeds scr_w[lo..hi-1]; out_ready is low for
  // five cycles starting at relative cycle stall_at (negative: no stall).
  task automatic run_beats(input int lo, input int hi, input int stall_at);
    int          idx;
    int          cyc;
    logic        fire;
    logic [11:0] held;
    idx  = lo;
    cyc  = 0;
    held = '0;
    while (idx < hi && cyc < 400) begin
      out_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      in_valid  = 1'b1;
      in_data   = scr_w[idx];
      #1;
      if (stall_at >= 0 && cyc == stall_at) held = out_data;
      if (stall_at >= 0 && cyc > stall_at && cyc < stall_at + 5) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_hold", 64'(out_data), 64'(held));
        chk("stall_valid", 64'(out_valid), 64'd1);
      end
      fire = in_ready;
      @(posedge clk); #1;
      if (fire) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (idx != hi) chk("feed_timeout", 64'(idx), 64'(hi));
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [42:0] seed_a, seed_b;
    logic [42:0] s_end;

    rst = 1'b1; start = 1'b0; seed_load = '0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; done_cnt = 0; done_at = 0;

    // Seed 0 / zero data stays all-zero; bit-42 seed gives hand-computed beats.
    tbl[0] = '{1'b1, 43'h0,            1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 43'h0,            1'b1};
    tbl[1] = '{1'b0, 43'h0,            1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 43'h0,            1'b1};
    tbl[2] = '{1'b0, 43'h0,            1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 43'h0,            1'b1};
    tbl[3] = '{1'b0, 43'h0,            1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 43'h0,            1'b1};
    tbl[4] = '{1'b0, 43'h0,            1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 43'h0,            1'b1};
    tbl[5] = '{1'b1, 43'h400_0000_0000, 1'b0, 12'h000, 1'b1, 1'b0, 12'h000, 43'h400_0000_0000, 1'b1};
    tbl[6] = '{1'b0, 43'h0,            1'b1, 12'h000, 1'b1, 1'b1, 12'h001, 43'h042_0001_0000, 1'b1};
    tbl[7] = '{1'b0, 43'h0,            1'b1, 12'h000, 1'b1, 1'b1, 12'h210, 43'h004_1100_1080, 1'b1};

    // Reset state
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_state",     64'(state_out), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    rst = 1'b0;
    tick();
    chk("idle_in_ready", 64'(in_ready), 64'd0);

    // Vector table
    for (int v = 0; v < 8; v++) begin
      start = tbl[v].st; seed_load = tbl[v].seed; in_valid = tbl[v].iv;
      in_data = tbl[v].id; out_ready = tbl[v].ordy;
      tick();
      chk($sformatf("v%0d_out_valid", v), 64'(out_valid), 64'(tbl[v].ov));
      chk($sformatf("v%0d_out_data", v),  64'(out_data),  64'(tbl[v].od));
      chk($sformatf("v%0d_state", v),     64'(state_out), 64'(tbl[v].sto));
      chk($sformatf("v%0d_busy", v),      64'(busy),      64'(tbl[v].bsy));
      chk($sformatf("v%0d_done", v),      64'(done),      64'd0);
    end
    start = 1'b0; in_valid = 1'b0;

    // Round trip with a 5-cycle backpressure window mid-frame
    seed_a = 43'h123_4567_89AB;
    s_end  = make_frame(seed_a);
    start = 1'b1; seed_load = seed_a; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("rt_busy", 64'(busy), 64'd1);
    chk("rt_seed", 64'(state_out), 64'(seed_a));
    outq.delete(); done_cnt = 0; done_at = 0;
    run_beats(0, 64, 20);
    chk("rt_busy_end", 64'(busy), 64'd0);
    chk("rt_state_end", 64'(state_out), 64'(s_end));
    tick(); tick();
    chk("rt_count", 64'(outq.size()), 64'd64);
    for (int i = 0; i < 64 && i < outq.size(); i++)
      chk($sformatf("rt_word%0d", i), 64'(outq[i]), 64'(plain[i]));
    chk("rt_done_cnt", 64'(done_cnt), 64'd1);
    chk("rt_done_at",  64'(done_at),  64'd64);

    // Abort: start at beat 10 with in_valid high discards that beat
    seed_a = 43'h0AA_5555_1234;
    seed_b = 43'h7F0_0F0F_00FF;
    s_end  = make_frame(seed_a);
    start = 1'b1; seed_load = seed_a;
    tick();
    start = 1'b0;
    run_beats(0, 10, -1);
    start = 1'b1; seed_load = seed_b; in_valid = 1'b1; in_data = 12'hABC; out_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    chk("ab_state", 64'(state_out), 64'(seed_b));
    chk("ab_out_valid", 64'(out_valid), 64'd0);
    chk("ab_busy", 64'(busy), 64'd1);
    outq.delete(); done_cnt = 0; done_at = 0;
    s_end = make_frame(seed_b);
    run_beats(0, 63, -1);
    tick();
    chk("ab_no_early_done", 64'(done_cnt), 64'd0);
    chk("ab_busy_63", 64'(busy), 64'd1);
    run_beats(63, 64, -1);
    tick();
    chk("ab_done_cnt", 64'(done_cnt), 64'd1);
    chk("ab_state_end", 64'(state_out), 64'(s_end));
    chk("ab_count", 64'(outq.size()), 64'd64);
    for (int i = 0; i < 64 && i < outq.size(); i++)
      chk($sformatf("ab_word%0d", i), 64'(outq[i]), 64'(plain[i]));

    // Reset mid-frame with a pending output beat
    start = 1'b1; seed_load = 43'h555_AAAA_5555;
    tick();
    start = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 12'h123;
    tick();
    chk("mr_pending", 64'(out_valid), 64'd1);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_data",  64'(out_data),  64'd0);
    chk("mr_state",     64'(state_out), 64'd0);
    chk("mr_busy",      64'(busy),      64'd0);
    chk("mr_done",      64'(done),      64'd0);
    chk("mr_in_ready",  64'(in_ready),  64'd0);
    tick(); tick();
    chk("mr_idle_ready", 64'(in_ready), 64'd0);
    chk("mr_idle_busy",  64'(busy),     64'd0);
    chk("mr_idle_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
